// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   F3_SB/F3_SH/F3_SW : store funct3 encodings
//   sb_entry_t        : one store-buffer entry {word index, lane-aligned data, byte mask}
//   ADDR_LSB          : first byte-address bit of the word index
//   merge_bytes()     : overlay new bytes onto an old word under a byte mask
package dmem_pkg;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  localparam int unsigned ADDR_LSB = 2;

  typedef struct packed {
    logic [10:0] widx;
    logic [31:0] data;
    logic [3:0]  mask;
  } sb_entry_t;

  function automatic logic [31:0] merge_bytes(logic [31:0] old_word, logic [31:0] new_word,
                                              logic [3:0] mask);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sb_fifo.sv
// Circular store buffer of SB_DEPTH entries.
//   clk_i, rstn_i  : clock, async active-low reset
//   push_i         : append push_entry_i at the tail
//   full_o         : all entries occupied
//   count_o        : occupied entries
//   ord_entry_o[k] : k-th oldest entry (k = 0 is the head)
//   ord_valid_o[k] : k-th oldest entry is occupied
// The head is popped on every edge where the buffer is non-empty; the consumer must write
// ord_entry_o[0] whenever ord_valid_o[0] is high.
module sb_fifo
  import dmem_pkg::*;
#(
  parameter int unsigned SB_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          push_i,
  input  sb_entry_t                     push_entry_i,
  output logic                          full_o,
  output logic [$clog2(SB_DEPTH):0]     count_o,
  output sb_entry_t [SB_DEPTH-1:0]      ord_entry_o,
  output logic [SB_DEPTH-1:0]           ord_valid_o
);

  localparam int unsigned PtrW = $clog2(SB_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pop;
  sb_entry_t [SB_DEPTH-1:0] entries_q;

  assign pop     = (cnt_q != '0);
  assign full_o  = (cnt_q == CntW'(SB_DEPTH));
  assign count_o = cnt_q;

  // Pointers wrap naturally because SB_DEPTH is a power of two.
  always_comb begin
    wr_d  = push_i ? wr_q + 1'b1 : wr_q;
    rd_d  = pop ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + CntW'(push_i) - CntW'(pop);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Payload needs no reset: occupancy is tracked by the count alone.
  always_ff @(posedge clk_i) begin
    if (push_i) entries_q[wr_q] <= push_entry_i;
  end

  // Age-ordered view, oldest first, for drain and forwarding.
  always_comb begin
    for (int k = 0; k < SB_DEPTH; k++) begin
      ord_entry_o[k] = entries_q[rd_q + PtrW'(k)];
      ord_valid_o[k] = (CntW'(k) < cnt_q);
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: buffers stores, drains them into a word array, and serves
// lane-aligned loads with forwarding from the store buffer.
//   clk_i, rstn_i                 : clock, async active-low reset
//   st_valid_i / st_ready_o       : store request handshake
//   st_adres_i/st_data_i/st_funct3_i : store byte address, right-aligned data, SB/SH/SW
//   ld_adres_i / ld_data_o        : load address, addressed word shifted to lane 0
//   sb_count_o                    : occupied store-buffer entries
//   st_err_o                      : pulses the cycle after an accepted request is dropped
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 2048,
  parameter int unsigned SB_DEPTH  = 4
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      st_valid_i,
  output logic                      st_ready_o,
  input  logic [31:0]               st_adres_i,
  input  logic [31:0]               st_data_i,
  input  logic [2:0]                st_funct3_i,
  input  logic [31:0]               ld_adres_i,
  output logic [31:0]               ld_data_o,
  output logic [$clog2(SB_DEPTH):0] sb_count_o,
  output logic                      st_err_o
);

  logic                      full;
  logic                      accept;
  logic                      push;
  logic                      enc_ok;
  sb_entry_t                 enc_entry;
  sb_entry_t [SB_DEPTH-1:0]  ord_entry;
  logic [SB_DEPTH-1:0]       ord_valid;
  logic                      err_q;
  logic [31:0]               mem_q [MEM_WORDS];
  logic [10:0]               ld_widx;
  logic [31:0]               ld_word;

  // Upper address bits alias modulo 8 KiB.
  logic unused_adr;
  assign unused_adr = ^{st_adres_i[31:13], ld_adres_i[31:13]};

  assign st_ready_o = ~full;
  assign accept     = st_valid_i & st_ready_o;
  assign push       = accept & enc_ok;
  assign st_err_o   = err_q;

  // Request encoder: lane-align data by replication and build the byte mask.
  always_comb begin
    enc_entry      = '0;
    enc_entry.widx = st_adres_i[ADDR_LSB +: 11];
    enc_ok         = 1'b0;
    case (st_funct3_i)
      F3_SB: begin
        enc_entry.mask = 4'b0001 << st_adres_i[1:0];
        enc_entry.data = {4{st_data_i[7:0]}};
        enc_ok         = 1'b1;
      end
      F3_SH: begin
        enc_entry.mask = st_adres_i[1] ? 4'b1100 : 4'b0011;
        enc_entry.data = {2{st_data_i[15:0]}};
        enc_ok         = ~st_adres_i[0];
      end
      F3_SW: begin
        enc_entry.mask = 4'b1111;
        enc_entry.data = st_data_i;
        enc_ok         = (st_adres_i[1:0] == 2'b00);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) err_q <= 1'b0;
    else         err_q <= accept & ~enc_ok;
  end

  sb_fifo #(
    .SB_DEPTH (SB_DEPTH)
  ) u_sb_fifo (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .push_i       (push),
    .push_entry_i (enc_entry),
    .full_o       (full),
    .count_o      (sb_count_o),
    .ord_entry_o  (ord_entry),
    .ord_valid_o  (ord_valid)
  );

  // Drain: head is written whenever the buffer is non-empty (the FIFO pops in lockstep).
  // The array is deliberately not reset; drained contents survive a reset.
  always_ff @(posedge clk_i) begin
    if (ord_valid[0]) begin
      for (int b = 0; b < 4; b++) begin
        if (ord_entry[0].mask[b]) mem_q[ord_entry[0].widx][8*b +: 8] <= ord_entry[0].data[8*b +: 8];
      end
    end
  end

  // Load: array word overlaid by matching buffered stores, oldest to youngest.
  assign ld_widx = ld_adres_i[ADDR_LSB +: 11];

  always_comb begin
    ld_word = mem_q[ld_widx];
    for (int k = 0; k < SB_DEPTH; k++) begin
      if (ord_valid[k] && (ord_entry[k].widx == ld_widx)) begin
        ld_word = merge_bytes(ld_word, ord_entry[k].data, ord_entry[k].mask);
      end
    end
    ld_data_o = ld_word >> {ld_adres_i[1:0], 3'b000};
  end

endmodule
